// File: rtl/fnd_share_ctrl_if.sv
// ---------------------------------------------------------------------------
// fnd_share_ctrl_if
// Requester-side bundle of the shared FND display arbiter.
//   REQ   [2:0]  per-requester request, level-held while the display is wanted
//   DATA0 [15:0] requester 0 BCD word, [15:12] is the leftmost digit
//   DATA1 [15:0] requester 1 BCD word
//   DATA2 [15:0] requester 2 BCD word
//   GNT   [2:0]  one-hot grant back to the requesters, 000 when idle
//   BUSY         high while any grant is active
// Modports:
//   master - requester side (drives REQ/DATAx, observes GNT/BUSY)
//   slave  - arbiter side   (observes REQ/DATAx, drives GNT/BUSY)
// ---------------------------------------------------------------------------
interface fnd_share_ctrl_if;
    logic [2:0]  REQ;
    logic [15:0] DATA0;
    logic [15:0] DATA1;
    logic [15:0] DATA2;
    logic [2:0]  GNT;
    logic        BUSY;

    modport master (
        output REQ,
        output DATA0,
        output DATA1,
        output DATA2,
        input  GNT,
        input  BUSY
    );

    modport slave (
        input  REQ,
        input  DATA0,
        input  DATA1,
        input  DATA2,
        output GNT,
        output BUSY
    );
endinterface

// File: rtl/fnd_share_ctrl.sv
// ---------------------------------------------------------------------------
// fnd_share_ctrl
// Shares one 4-digit common-select FND display between three requesters.
// Ownership is granted round-robin; a new owner keeps the display for at
// least HOLD_CYC cycles unless it releases it itself. The owner's live BCD
// word is scanned onto the digit/segment pins one digit per SCAN_DIV cycles.
//
// Ports:
//   CLK       system clock, all logic on the rising edge
//   RESET     synchronous reset, active-low
//   bus       requester bundle (slave side): REQ, DATA0..2 in; GNT, BUSY out
//   FND_COM   [3:0] one-hot digit select, registered, 0000 when idle
//   FND_DATA  [7:0] segments {a..g,dp}, active-low, registered, FF when idle
//
// Parameters:
//   SCAN_DIV  clock cycles per digit slot (>= 2)
//   HOLD_CYC  minimum ownership in cycles before another requester may
//             take the display over (>= 2)
// ---------------------------------------------------------------------------
module fnd_share_ctrl #(
    parameter int unsigned SCAN_DIV = 65536,
    parameter int unsigned HOLD_CYC = 24000000
) (
    input  logic                    CLK,
    input  logic                    RESET,
    fnd_share_ctrl_if.slave         bus,
    output logic [3:0]              FND_COM,
    output logic [7:0]              FND_DATA
);

    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOCK = 2'd1,
        ST_OPEN = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------

    // Round-robin pick: first set bit of mask searching from (ptr+1) mod 3
    // upward. Returns a one-hot vector, or 000 when the mask is empty.
    function automatic logic [2:0] rr_pick(input logic [1:0] ptr,
                                           input logic [2:0] mask);
        logic [2:0] res;
        res = 3'b000;
        case (ptr)
            2'd0: begin
                if      (mask[1]) res = 3'b010;
                else if (mask[2]) res = 3'b100;
                else if (mask[0]) res = 3'b001;
                else              res = 3'b000;
            end
            2'd1: begin
                if      (mask[2]) res = 3'b100;
                else if (mask[0]) res = 3'b001;
                else if (mask[1]) res = 3'b010;
                else              res = 3'b000;
            end
            default: begin
                // ptr == 2 (and the unused code 3) start the search at 0
                if      (mask[0]) res = 3'b001;
                else if (mask[1]) res = 3'b010;
                else if (mask[2]) res = 3'b100;
                else              res = 3'b000;
            end
        endcase
        return res;
    endfunction

    // One-hot grant to requester index; an empty grant maps to 2 so that a
    // following search starts at requester 0.
    function automatic logic [1:0] oh_to_idx(input logic [2:0] oh);
        logic [1:0] idx;
        case (oh)
            3'b001:  idx = 2'd0;
            3'b010:  idx = 2'd1;
            3'b100:  idx = 2'd2;
            default: idx = 2'd2;
        endcase
        return idx;
    endfunction

    // BCD nibble to active-low {a..g,dp}; non-decimal nibbles blank the digit.
    function automatic logic [7:0] seg_encode(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'd0:    seg = 8'b0000_0011;
            4'd1:    seg = 8'b1001_1111;
            4'd2:    seg = 8'b0010_0101;
            4'd3:    seg = 8'b0000_1101;
            4'd4:    seg = 8'b1001_1001;
            4'd5:    seg = 8'b0100_1001;
            4'd6:    seg = 8'b0100_0001;
            4'd7:    seg = 8'b0001_1011;
            4'd8:    seg = 8'b0000_0001;
            4'd9:    seg = 8'b0000_1001;
            default: seg = 8'b1111_1111;
        endcase
        return seg;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t              state_r;
    logic [2:0]          gnt_r;
    logic                busy_r;
    logic [1:0]          ptr_r;
    logic [HOLD_W-1:0]   hold_r;
    logic [SCAN_W-1:0]   scan_cnt_r;
    logic [1:0]          dig_idx_r;
    logic [3:0]          fnd_com_r;
    logic [7:0]          fnd_data_r;

    // -----------------------------------------------------------------------
    // Arbitration decode
    // -----------------------------------------------------------------------
    logic [2:0]  other_req_s;
    logic [2:0]  pick_any_s;
    logic [2:0]  pick_other_s;
    logic        owner_req_s;
    logic        hold_done_s;

    // Candidate grants and owner status for the FSM.
    always_comb begin
        other_req_s  = bus.REQ & ~gnt_r;
        pick_any_s   = rr_pick(ptr_r, bus.REQ);
        // Excluding the owner also covers the owner-drop case, where its
        // request bit is already clear.
        pick_other_s = rr_pick(ptr_r, other_req_s);
        owner_req_s  = |(bus.REQ & gnt_r);
        hold_done_s  = (hold_r == HOLD_LAST);
    end

    // Grant FSM with registered GNT/BUSY; BUSY always moves with GNT.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_r <= ST_IDLE;
            gnt_r   <= 3'b000;
            busy_r  <= 1'b0;
            ptr_r   <= 2'd2;
            hold_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.REQ != 3'b000) begin
                        gnt_r   <= pick_any_s;
                        busy_r  <= 1'b1;
                        ptr_r   <= oh_to_idx(pick_any_s);
                        hold_r  <= '0;
                        state_r <= ST_LOCK;
                    end else begin
                        gnt_r   <= 3'b000;
                        busy_r  <= 1'b0;
                    end
                end

                ST_LOCK: begin
                    // Owner release takes precedence over hold expiry.
                    if (!owner_req_s) begin
                        if (pick_other_s != 3'b000) begin
                            gnt_r   <= pick_other_s;
                            busy_r  <= 1'b1;
                            ptr_r   <= oh_to_idx(pick_other_s);
                            hold_r  <= '0;
                            state_r <= ST_LOCK;
                        end else begin
                            gnt_r   <= 3'b000;
                            busy_r  <= 1'b0;
                            hold_r  <= '0;
                            state_r <= ST_IDLE;
                        end
                    end else if (hold_done_s) begin
                        state_r <= ST_OPEN;
                    end else begin
                        hold_r  <= hold_r + HOLD_W'(1);
                    end
                end

                ST_OPEN: begin
                    // Hand over directly, so GNT never passes through 000.
                    if (pick_other_s != 3'b000) begin
                        gnt_r   <= pick_other_s;
                        busy_r  <= 1'b1;
                        ptr_r   <= oh_to_idx(pick_other_s);
                        hold_r  <= '0;
                        state_r <= ST_LOCK;
                    end else if (!owner_req_s) begin
                        gnt_r   <= 3'b000;
                        busy_r  <= 1'b0;
                        hold_r  <= '0;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_OPEN;
                    end
                end

                default: begin
                    // Unreachable encoding: drop any grant and restart.
                    gnt_r   <= 3'b000;
                    busy_r  <= 1'b0;
                    hold_r  <= '0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Free-running digit scan, independent of grant changes.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            scan_cnt_r <= '0;
            dig_idx_r  <= 2'd0;
        end else if (scan_cnt_r == SCAN_LAST) begin
            scan_cnt_r <= '0;
            dig_idx_r  <= dig_idx_r + 2'd1;
        end else begin
            scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Display path
    // -----------------------------------------------------------------------
    logic [15:0] word_s;
    logic [3:0]  nibble_s;
    logic [3:0]  com_s;

    // Select the current owner's live word and the digit being scanned.
    always_comb begin
        case (gnt_r)
            3'b001:  word_s = bus.DATA0;
            3'b010:  word_s = bus.DATA1;
            3'b100:  word_s = bus.DATA2;
            default: word_s = 16'h0000;
        endcase

        case (dig_idx_r)
            2'd0:    begin nibble_s = word_s[15:12]; com_s = 4'b1000; end
            2'd1:    begin nibble_s = word_s[11:8];  com_s = 4'b0100; end
            2'd2:    begin nibble_s = word_s[7:4];   com_s = 4'b0010; end
            default: begin nibble_s = word_s[3:0];   com_s = 4'b0001; end
        endcase
    end

    // Register the digit select and segments; blank whenever nobody owns
    // the display.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            fnd_com_r  <= 4'b0000;
            fnd_data_r <= 8'hFF;
        end else if (gnt_r == 3'b000) begin
            fnd_com_r  <= 4'b0000;
            fnd_data_r <= 8'hFF;
        end else begin
            fnd_com_r  <= com_s;
            fnd_data_r <= seg_encode(nibble_s);
        end
    end

    assign bus.GNT  = gnt_r;
    assign bus.BUSY = busy_r;
    assign FND_COM  = fnd_com_r;
    assign FND_DATA = fnd_data_r;

endmodule
